// File: rtl/cache_pkg.sv
// Shared constants for the cache-miss fill controller: block geometry,
// counter width, state encoding and the block/word address composer.
package cache_pkg;

    localparam int ADDR_WIDTH        = 16;
    localparam int DATA_WIDTH        = 16;
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int MEM_LATENCY       = 4;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_OFFSET_BITS  = 3;
    localparam int CNT_WIDTH         = WORD_OFFSET_BITS + 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_FILL = 1'b1;

    // The word offset lands in bits [3:1]; the block bits above are never carried into.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [ADDR_WIDTH-1:BLOCK_OFFSET_BITS] blk,
        input logic [CNT_WIDTH-1:0]                  cnt
    );
        return {blk, BLOCK_OFFSET_BITS'({cnt, 1'b0})};
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Synchronous clear/increment counter with a terminal-count flag,
// used for both the issue and the receive side of a block fill.
module fill_counter
    import cache_pkg::*;
#(
    parameter int WIDTH    = CNT_WIDTH,
    parameter int TC_VALUE = WORDS_PER_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == WIDTH'(TC_VALUE));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache-miss fill controller: fetches one 8-word block from pipelined memory,
// streams each returned word into the data array and writes the tag with the last.
//
// state | meaning
// IDLE  | waiting for a miss; latches the block base when one is seen
// FILL  | issuing block reads and writing returned words into the cache
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic [DATA_WIDTH-1:0] memory_data,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] cache_word_addr,
    output logic [DATA_WIDTH-1:0] fill_data
);

    logic                                  r_state;
    logic                                  w_next_state;
    logic [ADDR_WIDTH-1:BLOCK_OFFSET_BITS] r_block;
    logic [CNT_WIDTH-1:0]                  w_issue_cnt;
    logic [CNT_WIDTH-1:0]                  w_recv_cnt;
    logic                                  w_issue_done;
    logic                                  w_recv_last;
    logic                                  w_start;
    logic                                  w_issue;
    logic                                  w_recv;
    logic                                  w_unused_ok;

    assign w_start = !rst && (r_state == ST_IDLE) && miss_detected;
    assign w_issue = !rst && (r_state == ST_FILL) && !w_issue_done;
    assign w_recv  = !rst && (r_state == ST_FILL) && memory_data_valid;

    // The byte offset within the block is discarded: fills always start at word 0.
    assign w_unused_ok = &{1'b0, miss_address[BLOCK_OFFSET_BITS-1:0]};

    fill_counter #(
        .WIDTH    (CNT_WIDTH),
        .TC_VALUE (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start),
        .i_inc   (w_issue),
        .o_count (w_issue_cnt),
        .o_tc    (w_issue_done)
    );

    fill_counter #(
        .WIDTH    (CNT_WIDTH),
        .TC_VALUE (WORDS_PER_BLOCK - 1)
    ) u_recv_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start),
        .i_inc   (w_recv),
        .o_count (w_recv_cnt),
        .o_tc    (w_recv_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_block <= '0;
        end else if (w_start) begin
            r_block <= miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_BITS];
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (miss_detected)          w_next_state = ST_FILL;
            ST_FILL: if (w_recv && w_recv_last) w_next_state = ST_IDLE;
            default:                             w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are held at zero while reset is asserted, even mid-fill.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_word_addr  = '0;
        if (!rst && (r_state == ST_FILL)) begin
            fsm_busy = 1'b1;
            if (w_issue) begin
                mem_read_en    = 1'b1;
                memory_address = word_addr(r_block, w_issue_cnt);
            end
            if (w_recv) begin
                write_data_array = 1'b1;
                cache_word_addr  = word_addr(r_block, w_recv_cnt);
                write_tag_array  = w_recv_last;
            end
        end
    end

    assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: directed per-cycle stimulus pushes the
// hand-derived expected outputs; a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic [15:0] memory_data = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_word_addr;
    logic [15:0] fill_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        busy;
        logic        rd;
        logic [15:0] maddr;
        logic        wr;
        logic [15:0] waddr;
        logic        tag;
        logic [15:0] fdata;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_word_addr   (cache_word_addr),
        .fill_data         (fill_data)
    );

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (fsm_busy !== e.busy || mem_read_en !== e.rd || memory_address !== e.maddr ||
                write_data_array !== e.wr || cache_word_addr !== e.waddr ||
                write_tag_array !== e.tag || fill_data !== e.fdata) begin
                errors++;
                $display("FAIL %s t=%0t got busy=%b rd=%b maddr=%h wr=%b waddr=%h tag=%b fdata=%h exp busy=%b rd=%b maddr=%h wr=%b waddr=%h tag=%b fdata=%h",
                         e.name, $time, fsm_busy, mem_read_en, memory_address, write_data_array,
                         cache_word_addr, write_tag_array, fill_data, e.busy, e.rd, e.maddr,
                         e.wr, e.waddr, e.tag, e.fdata);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic m, input logic [15:0] ma,
                        input logic v, input logic [15:0] md,
                        input logic eb, input logic erd, input logic [15:0] eaddr,
                        input logic ewr, input logic [15:0] ewaddr, input logic etag);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        miss_detected     = m;
        miss_address      = ma;
        memory_data_valid = v;
        memory_data       = md;
        e.name  = nm;
        e.busy  = eb;
        e.rd    = erd;
        e.maddr = eaddr;
        e.wr    = ewr;
        e.waddr = ewaddr;
        e.tag   = etag;
        e.fdata = md;
        exp_q.push_back(e);
    endtask

    task automatic idle_step(input string nm);
        step(nm, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    // Cycle 0 presents the miss; reads go out in cycles 1..8; valid cycles come from vmask.
    task automatic do_fill(input string nm, input logic [15:0] miss_a, input logic [15:0] base,
                           input logic [31:0] vmask, input int rst_k, input int alt_k,
                           input logic [15:0] alt_a);
        int          recv;
        logic [15:0] ma;
        logic        v;
        logic        erd;
        logic [15:0] eaddr;
        logic        ewr;
        logic [15:0] ewaddr;
        logic        etag;
        logic [15:0] md;
        recv = 0;
        ma   = miss_a;
        step(nm, 1'b0, 1'b1, ma, 1'b0, 16'h7000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int k = 1; k < 32; k++) begin
            if (k == alt_k) ma = alt_a;
            if (k == rst_k) begin
                step({nm, "_rst"}, 1'b1, 1'b1, ma, 1'b1, 16'h5555,
                     1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
                break;
            end
            v      = vmask[k];
            erd    = (k <= 8);
            eaddr  = erd ? base + 16'(2 * (k - 1)) : 16'h0;
            ewr    = 1'b0;
            ewaddr = 16'h0;
            etag   = 1'b0;
            md     = 16'h7000 + 16'(k);
            if (v) begin
                ewr    = 1'b1;
                ewaddr = base + 16'(2 * recv);
                etag   = (recv == 7);
                md     = 16'hA000 + 16'(recv);
                recv++;
            end
            step(nm, 1'b0, 1'b1, ma, v, md, 1'b1, erd, eaddr, ewr, ewaddr, etag);
            if (etag) break;
        end
    endtask

    localparam logic [31:0] MASK_BASIC = 32'h0000_1FE0;
    localparam logic [31:0] MASK_STALL = 32'h0014_A5A0;

    initial begin
        step("reset", 1'b1, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        step("reset_miss", 1'b1, 1'b1, 16'h1236, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        step("idle_valid", 1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        step("idle_valid", 1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

        do_fill("basic", 16'h1236, 16'h1230, MASK_BASIC, -1, -1, 16'h0);
        idle_step("basic_done");
        idle_step("idle");

        do_fill("addr_change", 16'h1236, 16'h1230, MASK_BASIC, -1, 3, 16'h8000);
        do_fill("refill", 16'h8000, 16'h8000, MASK_BASIC, -1, -1, 16'h0);
        idle_step("refill_done");

        do_fill("stall", 16'h4A5C, 16'h4A50, MASK_STALL, -1, -1, 16'h0);
        idle_step("stall_done");

        do_fill("rst_mid", 16'h2468, 16'h2460, MASK_BASIC, 8, -1, 16'h0);
        idle_step("after_rst_idle");
        do_fill("after_rst", 16'h00F2, 16'h00F0, MASK_BASIC, -1, -1, 16'h0);
        idle_step("after_rst_done");

        do_fill("wrap", 16'hFFFF, 16'hFFF0, MASK_BASIC, -1, -1, 16'h0);
        idle_step("wrap_done");
        idle_step("end");

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
